// File: rtl/adder_accum_ctrl.sv
// Sequencing stage in front of a WIDTH-bit adder. The Run button is synchronized and
// edge-detected, and each press performs one accumulate: acc <= acc + SW.
// The adder itself is external and connects through the Add_* ports.
module adder_accum_ctrl #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned ADD_LAT     = 1,   // legal 1..15
    parameter int unsigned SYNC_STAGES = 2    // legal 2..4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run_Accumulate,
    input  logic             Clear,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Add_A,
    output logic [WIDTH-1:0] Add_B,
    output logic             Add_cin,
    input  logic [WIDTH-1:0] Add_S,
    input  logic             Add_cout,
    output logic [WIDTH-1:0] Out,
    output logic             Carry,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CntW = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWait,
        StCapture,
        StHold
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   run_d_q, run_d_d;
    logic [WIDTH-1:0]       acc_q, acc_d;
    logic [WIDTH-1:0]       op_q, op_d;
    logic                   carry_q, carry_d;
    logic                   done_q, done_d;
    logic [CntW-1:0]        cnt_q, cnt_d;

    logic run_s;
    logic press;

    // Synchronizer shift and edge-detect delay for the Run button.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], Run_Accumulate};
        run_d_d = run_s;
    end

    assign run_s = sync_q[SYNC_STAGES-1];
    assign press = run_s & ~run_d_q;

    // Next-state and datapath updates; Clear overrides everything the FSM decided.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (press) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                op_d    = SW;
                cnt_d   = CntW'(ADD_LAT - 1);
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCapture: begin
                acc_d   = Add_S;
                carry_d = Add_cout;
                done_d  = 1'b1;
                state_d = StHold;
            end
            StHold: begin
                // Wait for release so a held button yields only one add.
                if (!run_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Parking in HOLD keeps a still-held button from retriggering after Clear.
        if (Clear) begin
            acc_d   = '0;
            op_d    = '0;
            carry_d = 1'b0;
            done_d  = 1'b0;
            cnt_d   = '0;
            state_d = StHold;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            sync_q  <= '0;
            run_d_q <= 1'b0;
            acc_q   <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            run_d_q <= run_d_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Add_A   = acc_q;
    assign Add_B   = op_q;
    assign Add_cin = 1'b0;
    assign Out     = acc_q;
    assign Carry   = carry_q;
    assign Done    = done_q;
    assign Busy    = (state_q == StLoad) || (state_q == StWait) || (state_q == StCapture);

endmodule

// File: tb/tb_adder_accum_ctrl.sv
// Directed bench for adder_accum_ctrl. Three instances cover the default
// configuration, ADD_LAT=3 (abort), and SYNC_STAGES=3/ADD_LAT=2 (latency, reset mid-op).
// Each instance is paired with a behavioural adder.
module tb_adder_accum_ctrl;

    logic Clk;
    logic Reset;

    // Instance A: defaults
    logic        run_a, clr_a;
    logic [15:0] sw_a, a_adda, a_addb, a_s, a_out;
    logic        a_cin, a_cout, a_carry, a_busy, a_done;
    logic [16:0] sum_a;

    // Instance B: ADD_LAT=3
    logic        run_b, clr_b;
    logic [15:0] sw_b, b_adda, b_addb, b_s, b_out;
    logic        b_cin, b_cout, b_carry, b_busy, b_done;
    logic [16:0] sum_b;

    // Instance C: SYNC_STAGES=3, ADD_LAT=2
    logic        run_c, clr_c;
    logic [15:0] sw_c, c_adda, c_addb, c_s, c_out;
    logic        c_cin, c_cout, c_carry, c_busy, c_done;
    logic [16:0] sum_c;

    int n_assert;
    int n_fail;
    int cnt;

    assign sum_a  = {1'b0, a_adda} + {1'b0, a_addb} + {16'd0, a_cin};
    assign a_s    = sum_a[15:0];
    assign a_cout = sum_a[16];
    assign sum_b  = {1'b0, b_adda} + {1'b0, b_addb} + {16'd0, b_cin};
    assign b_s    = sum_b[15:0];
    assign b_cout = sum_b[16];
    assign sum_c  = {1'b0, c_adda} + {1'b0, c_addb} + {16'd0, c_cin};
    assign c_s    = sum_c[15:0];
    assign c_cout = sum_c[16];

    adder_accum_ctrl u_dut_a (
        .Clk            (Clk),
        .Reset          (Reset),
        .Run_Accumulate (run_a),
        .Clear          (clr_a),
        .SW             (sw_a),
        .Add_A          (a_adda),
        .Add_B          (a_addb),
        .Add_cin        (a_cin),
        .Add_S          (a_s),
        .Add_cout       (a_cout),
        .Out            (a_out),
        .Carry          (a_carry),
        .Busy           (a_busy),
        .Done           (a_done)
    );

    adder_accum_ctrl #(
        .ADD_LAT (3)
    ) u_dut_b (
        .Clk            (Clk),
        .Reset          (Reset),
        .Run_Accumulate (run_b),
        .Clear          (clr_b),
        .SW             (sw_b),
        .Add_A          (b_adda),
        .Add_B          (b_addb),
        .Add_cin        (b_cin),
        .Add_S          (b_s),
        .Add_cout       (b_cout),
        .Out            (b_out),
        .Carry          (b_carry),
        .Busy           (b_busy),
        .Done           (b_done)
    );

    adder_accum_ctrl #(
        .SYNC_STAGES (3),
        .ADD_LAT     (2)
    ) u_dut_c (
        .Clk            (Clk),
        .Reset          (Reset),
        .Run_Accumulate (run_c),
        .Clear          (clr_c),
        .SW             (sw_c),
        .Add_A          (c_adda),
        .Add_B          (c_addb),
        .Add_cin        (c_cin),
        .Add_S          (c_s),
        .Add_cout       (c_cout),
        .Out            (c_out),
        .Carry          (c_carry),
        .Busy           (c_busy),
        .Done           (c_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One press/release on instance A; SW is scrambled after LOAD to prove it was latched.
    task automatic press_a(input logic [15:0] sw, input logic [15:0] exp_out,
                           input logic exp_c);
        sw_a  = sw;
        run_a = 1'b1;
        repeat (4) tick();
        check("a_load_addb", {16'd0, a_addb}, {16'd0, sw});
        check("a_load_busy", {31'd0, a_busy}, 32'd1);
        sw_a = ~sw;
        tick();
        check("a_done_early", {31'd0, a_done}, 32'd0);
        tick();
        check("a_done_edge6", {31'd0, a_done}, 32'd1);
        check("a_out", {16'd0, a_out}, {16'd0, exp_out});
        check("a_carry", {31'd0, a_carry}, {31'd0, exp_c});
        check("a_busy_hold", {31'd0, a_busy}, 32'd0);
        tick();
        check("a_done_pulse", {31'd0, a_done}, 32'd0);
        run_a = 1'b0;
        repeat (4) tick();
    endtask

    task automatic clear_a();
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        Reset = 1'b1;
        run_a = 1'b0; clr_a = 1'b0; sw_a = 16'h0;
        run_b = 1'b0; clr_b = 1'b0; sw_b = 16'h0;
        run_c = 1'b0; clr_c = 1'b0; sw_c = 16'h0;

        // T1 reset
        repeat (2) tick();
        check("t1_out", {16'd0, a_out}, 32'h0);
        check("t1_carry", {31'd0, a_carry}, 32'd0);
        check("t1_busy", {31'd0, a_busy}, 32'd0);
        check("t1_done", {31'd0, a_done}, 32'd0);
        check("t1_addb", {16'd0, a_addb}, 32'h0);
        check("t1_cin", {31'd0, a_cin}, 32'd0);
        check("t1_b_out", {16'd0, b_out}, 32'h0);
        check("t1_c_busy", {31'd0, c_busy}, 32'd0);
        Reset = 1'b0;
        repeat (2) tick();

        // T2 accumulate 5 twice
        press_a(16'h0005, 16'h0005, 1'b0);
        press_a(16'h0005, 16'h000A, 1'b0);

        // T3 held button: one add only
        clear_a();
        check("t3_cleared", {16'd0, a_out}, 32'h0);
        sw_a  = 16'h0003;
        run_a = 1'b1;
        cnt   = 0;
        repeat (100) begin
            tick();
            if (a_done) cnt++;
        end
        check("t3_one_done", cnt, 32'd1);
        check("t3_out", {16'd0, a_out}, 32'h3);
        run_a = 1'b0;
        repeat (4) tick();
        check("t3_idle_busy", {31'd0, a_busy}, 32'd0);

        // T4 wrap and non-sticky carry
        clear_a();
        press_a(16'hFFFF, 16'hFFFF, 1'b0);
        press_a(16'h0001, 16'h0000, 1'b1);
        press_a(16'h0000, 16'h0000, 1'b0);

        // Clear coincident with press: press discarded
        press_a(16'h0010, 16'h0010, 1'b0);
        sw_a  = 16'h1234;
        run_a = 1'b1;
        repeat (2) tick();
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("clrpress_busy", {31'd0, a_busy}, 32'd0);
        check("clrpress_out", {16'd0, a_out}, 32'h0);
        cnt = 0;
        repeat (10) begin
            tick();
            if (a_done || a_busy) cnt++;
        end
        check("clrpress_no_op", cnt, 32'd0);
        run_a = 1'b0;
        repeat (4) tick();

        // T5 abort in WAIT (ADD_LAT=3)
        sw_b  = 16'h0005;
        run_b = 1'b1;
        repeat (5) tick();
        check("t5_busy_wait", {31'd0, b_busy}, 32'd1);
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        check("t5_out", {16'd0, b_out}, 32'h0);
        check("t5_busy", {31'd0, b_busy}, 32'd0);
        check("t5_done", {31'd0, b_done}, 32'd0);
        cnt = 0;
        repeat (8) begin
            tick();
            if (b_done) cnt++;
        end
        check("t5_no_done", cnt, 32'd0);
        check("t5_out_after", {16'd0, b_out}, 32'h0);
        run_b = 1'b0;
        repeat (5) tick();
        sw_b  = 16'h0007;
        run_b = 1'b1;
        repeat (7) tick();
        check("t5_done_early", {31'd0, b_done}, 32'd0);
        tick();
        check("t5_done_edge8", {31'd0, b_done}, 32'd1);
        check("t5_out7", {16'd0, b_out}, 32'h7);
        run_b = 1'b0;
        repeat (5) tick();

        // T6 latency with SYNC_STAGES=3, ADD_LAT=2
        sw_c  = 16'h0009;
        run_c = 1'b1;
        repeat (7) tick();
        check("t6_done_early", {31'd0, c_done}, 32'd0);
        tick();
        check("t6_done_edge8", {31'd0, c_done}, 32'd1);
        check("t6_out9", {16'd0, c_out}, 32'h9);
        tick();
        run_c = 1'b0;
        repeat (6) tick();

        // T6 reset during CAPTURE
        sw_c  = 16'h0002;
        run_c = 1'b1;
        repeat (7) tick();
        check("t6_busy_capture", {31'd0, c_busy}, 32'd1);
        Reset = 1'b1;
        tick();
        check("t6_rst_out", {16'd0, c_out}, 32'h0);
        check("t6_rst_done", {31'd0, c_done}, 32'd0);
        check("t6_rst_busy", {31'd0, c_busy}, 32'd0);
        check("t6_rst_carry", {31'd0, c_carry}, 32'd0);
        run_c = 1'b0;
        Reset = 1'b0;
        cnt   = 0;
        repeat (6) begin
            tick();
            if (c_done) cnt++;
        end
        check("t6_no_done", cnt, 32'd0);
        check("t6_out_after", {16'd0, c_out}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
